// File: rtl/midi_byte_tx.sv
// MIDI OUT serializer: small byte FIFO feeding a 31250-baud 8N1 line driver (LSB first, idle high).
// Optional running-status suppression is built when MIDI_RUNNING_STATUS_EN is defined.
module midi_byte_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 31250,
  parameter int FIFO_AW  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data,
  output logic       tx_busy,
  output logic       fifo_empty,
  output logic       tx_active,
  output logic       midi_out
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int BW    = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [BW-1:0]      BAUD_LAST = BW'(CPB - 1);
  localparam logic [BW-1:0]      BAUD_ONE  = BW'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               out_q, out_d;
  logic               push, pop, load, skip, baud_end;
  logic [7:0]         head;

  assign tx_busy    = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign tx_active  = (state_q != IDLE);
  assign midi_out   = out_q;
  assign push       = new_tx_data && !tx_busy;
  assign head       = mem_q[rd_ptr_q];
  assign baud_end   = (baud_q == BAUD_LAST);

`ifdef MIDI_RUNNING_STATUS_EN
  // rs_q == 0 means "no running status"; channel status bytes are never zero.
  logic [7:0] rs_q, rs_d;

  assign skip = (head >= 8'h80) && (head <= 8'hEF) && (head == rs_q);

  always_comb begin
    rs_d = rs_q;
    if (load) begin
      if (head >= 8'h80 && head <= 8'hEF)      rs_d = head;
      else if (head >= 8'hF0 && head <= 8'hF7) rs_d = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rs_q <= 8'h00;
    else     rs_q <= rs_d;
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    out_d   = out_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = 1'b1;
        if (!fifo_empty) begin
          pop = 1'b1;
          if (!skip) begin
            load    = 1'b1;
            shift_d = head;
            baud_d  = '0;
            out_d   = 1'b0;
            state_d = START;
          end
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          out_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            out_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            out_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          out_d   = 1'b1;
          state_d = IDLE;
          // Chain straight into the next START so queued frames stay contiguous.
          if (!fifo_empty) begin
            pop = 1'b1;
            if (!skip) begin
              load    = 1'b1;
              shift_d = head;
              out_d   = 1'b0;
              state_d = START;
            end
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      out_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_midi_byte_tx.sv
// Bench for midi_byte_tx: a line decoder feeds received bytes to a scoreboard of expected bytes.
// Expectations follow MIDI_RUNNING_STATUS_EN when it is defined.
module tb_midi_byte_tx;

  localparam int BAUD     = 31250;
  localparam int CPB      = 16;
  localparam int CLK_FREQ = BAUD * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       new_tx_data = 1'b0;
  logic       tx_busy, fifo_empty, tx_active, midi_out;

  midi_byte_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .new_tx_data(new_tx_data),
    .tx_busy(tx_busy), .fifo_empty(fifo_empty), .tx_active(tx_active), .midi_out(midi_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_b[$];
  logic       rx_ok[$];
  logic [7:0] m_rs;

  // Line decoder: samples mid-bit after a falling edge, flags bad start/stop bits.
  logic       prev_line;
  logic       m_busy, m_ok;
  int         m_cnt, m_idx;
  logic [7:0] m_sh;

  always @(negedge clk) begin
    if (rst) begin
      m_busy    <= 1'b0;
      prev_line <= 1'b1;
    end else begin
      prev_line <= midi_out;
      if (!m_busy) begin
        if (prev_line && !midi_out) begin
          m_busy <= 1'b1;
          m_cnt  <= CPB / 2;
          m_idx  <= 0;
          m_ok   <= 1'b1;
        end
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else begin
        m_cnt <= CPB;
        m_idx <= m_idx + 1;
        if (m_idx == 0) begin
          if (midi_out) m_ok <= 1'b0;
        end else if (m_idx <= 8) begin
          m_sh <= {midi_out, m_sh[7:1]};
        end else begin
          rx_b.push_back(m_sh);
          rx_ok.push_back(m_ok && midi_out);
          m_busy <= 1'b0;
        end
      end
    end
  end

  int act_run = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (tx_active) act_run <= act_run + 1;
    else begin
      if (act_run != 0) last_run <= act_run;
      act_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void model_push(input logic [7:0] b);
`ifdef MIDI_RUNNING_STATUS_EN
    if (b >= 8'h80 && b <= 8'hEF) begin
      if (b == m_rs) return;
      m_rs = b;
    end else if (b >= 8'hF0 && b <= 8'hF7) begin
      m_rs = 8'h00;
    end
`endif
    exp_q.push_back(b);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    new_tx_data = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rx_b.delete();
    rx_ok.delete();
    m_rs = 8'h00;
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b);
    int waited = 0;
    while (tx_busy && waited < 20 * CPB) begin
      @(negedge clk);
      waited++;
    end
    if (tx_busy) check("wr_busy_timeout", {31'd0, tx_busy}, 32'd0);
    tx_data = b;
    new_tx_data = 1'b1;
    model_push(b);
    @(negedge clk);
    new_tx_data = 1'b0;
  endtask

  task automatic drain(input string tag);
    int waited;
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (rx_b.size() == 0 && waited < 12 * CPB) begin
        @(negedge clk);
        waited++;
      end
      if (rx_b.size() == 0) begin
        check({tag, "_timeout"}, rx_b.size(), 32'd1);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        check({tag, "_byte"}, {24'd0, rx_b.pop_front()}, {24'd0, e});
        check({tag, "_frame"}, {31'd0, rx_ok.pop_front()}, 32'd1);
      end
    end
    repeat (12 * CPB) @(negedge clk);
    check({tag, "_extra"}, rx_b.size(), 32'd0);
  endtask

  logic [7:0] seq2 [6] = '{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h11};
  logic [7:0] seq4 [6] = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64};

  initial begin
    m_rs = 8'h00;

    // single byte: reset values, latency, frame and active time
    do_reset();
    check("rst_midi_out", {31'd0, midi_out}, 32'd1);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_tx_active", {31'd0, tx_active}, 32'd0);
    tx_data = 8'h90;
    new_tx_data = 1'b1;
    model_push(8'h90);
    @(negedge clk);
    new_tx_data = 1'b0;
    check("t1_edge1_line", {31'd0, midi_out}, 32'd1);
    check("t1_edge1_empty", {31'd0, fifo_empty}, 32'd0);
    @(negedge clk);
    check("t1_edge2_line", {31'd0, midi_out}, 32'd0);
    check("t1_edge2_active", {31'd0, tx_active}, 32'd1);
    check("t1_edge2_empty", {31'd0, fifo_empty}, 32'd1);
    drain("t1");
    check("t1_active_len", last_run, 10 * CPB);

    // six back-to-back strobes, sixth hits a full FIFO
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("t2_busy_6th", {31'd0, tx_busy}, 32'd1);
      else model_push(seq2[i]);
      tx_data = seq2[i];
      new_tx_data = 1'b1;
      @(negedge clk);
    end
    new_tx_data = 1'b0;
    check("t2_busy_after", {31'd0, tx_busy}, 32'd1);
    drain("t2");
    check("t2_active_len", last_run, 50 * CPB);

    // reset in the middle of DATA bit 3
    do_reset();
    wr(8'h55);
    wr(8'h66);
    check("t3_started", {31'd0, midi_out}, 32'd0);
    check("t3_queued", {31'd0, fifo_empty}, 32'd0);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("t3_bit3_low", {31'd0, midi_out}, 32'd0);
    rst = 1'b1;
    #1;
    check("t3_async_line", {31'd0, midi_out}, 32'd1);
    check("t3_async_empty", {31'd0, fifo_empty}, 32'd1);
    check("t3_async_active", {31'd0, tx_active}, 32'd0);
    do_reset();
    wr(8'hA5);
    drain("t3");

    // running-status sequence
    do_reset();
    for (int i = 0; i < 6; i++) wr(seq4[i]);
    drain("t4");

    // realtime keeps running status, sysex clears it
    do_reset();
    wr(8'h90); wr(8'hF8); wr(8'h90);
    drain("t5a");
    do_reset();
    wr(8'h90); wr(8'hF0); wr(8'h90);
    drain("t5b");

    // write while full on the exact cycle a STOP ends and pops
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'(i + 1);
      new_tx_data = 1'b1;
      model_push(8'(i + 1));
      @(negedge clk);
    end
    new_tx_data = 1'b0;
    check("t6_full", {31'd0, tx_busy}, 32'd1);
    repeat (10 * CPB - 4) @(negedge clk);
    check("t6_stop_line", {31'd0, midi_out}, 32'd1);
    check("t6_stop_full", {31'd0, tx_busy}, 32'd1);
    tx_data = 8'hEE;
    new_tx_data = 1'b1;
    @(negedge clk);
    new_tx_data = 1'b0;
    check("t6_next_start", {31'd0, midi_out}, 32'd0);
    check("t6_count3", {31'd0, tx_busy}, 32'd0);
    check("t6_not_empty", {31'd0, fifo_empty}, 32'd0);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
